// File: rtl/bounce_gen_pkg.sv
// Shared types, constants and the LFSR-to-range mapping for the bounce generator.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OFF,
        ON
    } bounce_state_t;

    localparam int unsigned            LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0]  LFSR_MASK  = 16'hB400;

    // Scales the LFSR value onto [lo, hi] with a 32-bit product; lo==hi yields lo.
    function automatic logic [31:0] rand_range(input logic [LFSR_WIDTH-1:0] lfsr,
                                               input int unsigned lo,
                                               input int unsigned hi);
        logic [31:0] span;
        logic [31:0] prod;
        span = hi - lo + 32'd1;
        prod = {16'b0, lfsr} * span;
        return lo + (prod >> 16);
    endfunction

endpackage

// File: rtl/bounce_gen_chan.sv
// One bounce channel: FSM, segment/bounce counters, Galois LFSR.
// Toggle statistics are built only when BOUNCE_GEN_STATS_EN is defined.
module bounce_gen_chan
    import bounce_gen_pkg::*;
#(
    parameter int unsigned     BOUNCE_CLOCKS_MIN = 10,
    parameter int unsigned     BOUNCE_CLOCKS_MAX = 1000,
    parameter int unsigned     NUM_BOUNCES_MIN   = 2,
    parameter int unsigned     NUM_BOUNCES_MAX   = 5,
    parameter logic [15:0]     SEED              = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic        bounce_out,
    output logic        busy,
    output logic [15:0] toggle_count
);

    localparam int unsigned DW = $clog2(BOUNCE_CLOCKS_MAX + 1);
    localparam int unsigned BW = $clog2(NUM_BOUNCES_MAX + 1);
    localparam logic [DW-1:0] ONE_D = DW'(1);
    localparam logic [BW-1:0] ONE_B = BW'(1);

    bounce_state_t          state, state_nxt;
    logic                   target, target_nxt;
    logic                   out_nxt;
    logic [DW-1:0]          delay_cnt, delay_nxt;
    logic [BW-1:0]          bounces_left, bounces_nxt;
    logic [LFSR_WIDTH-1:0]  lfsr;
    logic [DW-1:0]          draw_delay;
    logic [BW-1:0]          draw_bounces;

    assign draw_delay   = DW'(rand_range(lfsr, BOUNCE_CLOCKS_MIN, BOUNCE_CLOCKS_MAX));
    assign draw_bounces = BW'(rand_range(lfsr, NUM_BOUNCES_MIN, NUM_BOUNCES_MAX));
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            target       <= 1'b0;
            bounce_out   <= 1'b0;
            delay_cnt    <= '0;
            bounces_left <= '0;
            lfsr         <= SEED;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            bounce_out   <= out_nxt;
            delay_cnt    <= delay_nxt;
            bounces_left <= bounces_nxt;
            lfsr         <= {1'b0, lfsr[LFSR_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        out_nxt     = bounce_out;
        delay_nxt   = delay_cnt;
        bounces_nxt = bounces_left;
        case (state)
            IDLE: begin
                if (sig_in != bounce_out) begin
                    state_nxt   = OFF;
                    target_nxt  = sig_in;
                    bounces_nxt = draw_bounces;
                    delay_nxt   = draw_delay;
                end
            end
            OFF: begin
                // Input moving away from the target wins over a pending toggle.
                if (sig_in != target) begin
                    state_nxt = IDLE;
                end else if (delay_cnt == ONE_D) begin
                    out_nxt = target;
                    if (bounces_left == ONE_B) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ON;
                        delay_nxt = draw_delay;
                    end
                end else begin
                    delay_nxt = delay_cnt - ONE_D;
                end
            end
            ON: begin
                if (sig_in != target) begin
                    state_nxt = IDLE;
                end else if (delay_cnt == ONE_D) begin
                    out_nxt     = ~target;
                    bounces_nxt = bounces_left - ONE_B;
                    state_nxt   = OFF;
                    delay_nxt   = draw_delay;
                end else begin
                    delay_nxt = delay_cnt - ONE_D;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BOUNCE_GEN_STATS_EN
    logic [15:0] toggles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggles <= '0;
        end else if ((out_nxt != bounce_out) && (toggles != '1)) begin
            toggles <= toggles + 16'd1;
        end
    end

    assign toggle_count = toggles;
`else
    assign toggle_count = '0;
`endif

endmodule

// File: rtl/bounce_gen_multi.sv
// Multi-channel bounce generator: one bounce_gen_chan per input bit.
// Define BOUNCE_GEN_STATS_EN to build the per-channel toggle counters.
module bounce_gen_multi
    import bounce_gen_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned BOUNCE_CLOCKS_MIN = 10,
    parameter int unsigned BOUNCE_CLOCKS_MAX = 1000,
    parameter int unsigned NUM_BOUNCES_MIN   = 2,
    parameter int unsigned NUM_BOUNCES_MAX   = 5,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CHANNELS-1:0]    sig_in,
    output logic [NUM_CHANNELS-1:0]    bounce_out,
    output logic [NUM_CHANNELS-1:0]    busy,
    output logic [NUM_CHANNELS*16-1:0] toggle_count
);

    if (NUM_CHANNELS < 1) begin : g_bad_chan
        $error("bounce_gen_multi: NUM_CHANNELS must be >= 1");
    end
    if (BOUNCE_CLOCKS_MIN < 1) begin : g_bad_bcmin
        $error("bounce_gen_multi: BOUNCE_CLOCKS_MIN must be >= 1");
    end
    if (BOUNCE_CLOCKS_MAX < BOUNCE_CLOCKS_MIN) begin : g_bad_bcmax
        $error("bounce_gen_multi: BOUNCE_CLOCKS_MAX must be >= BOUNCE_CLOCKS_MIN");
    end
    if (NUM_BOUNCES_MIN < 1) begin : g_bad_nbmin
        $error("bounce_gen_multi: NUM_BOUNCES_MIN must be >= 1");
    end
    if (NUM_BOUNCES_MAX < NUM_BOUNCES_MIN) begin : g_bad_nbmax
        $error("bounce_gen_multi: NUM_BOUNCES_MAX must be >= NUM_BOUNCES_MIN");
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        // Per-channel seed wraps at 16 bits; an all-zero LFSR would lock up.
        localparam logic [15:0] SEED_RAW = LFSR_SEED + 16'(i);
        localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

        bounce_gen_chan #(
            .BOUNCE_CLOCKS_MIN (BOUNCE_CLOCKS_MIN),
            .BOUNCE_CLOCKS_MAX (BOUNCE_CLOCKS_MAX),
            .NUM_BOUNCES_MIN   (NUM_BOUNCES_MIN),
            .NUM_BOUNCES_MAX   (NUM_BOUNCES_MAX),
            .SEED              (SEED)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .sig_in       (sig_in[i]),
            .bounce_out   (bounce_out[i]),
            .busy         (busy[i]),
            .toggle_count (toggle_count[i*16 +: 16])
        );
    end

endmodule

// File: tb/tb_bounce_gen_multi.sv
// Randomized bench for bounce_gen_multi against an event-schedule reference model.
module tb_bounce_gen_multi;

    localparam int unsigned NC    = 4;
    localparam int unsigned BCMIN = 3;
    localparam int unsigned BCMAX = 12;
    localparam int unsigned NBMIN = 1;
    localparam int unsigned NBMAX = 4;
    localparam logic [15:0] SEED  = 16'hFFFF;
    localparam int unsigned NCYC  = 16000;
    localparam int unsigned RST_AT = 8000;

    logic               clk = 1'b0;
    logic               rst;
    logic [NC-1:0]      sig_in;
    logic [NC-1:0]      bounce_out;
    logic [NC-1:0]      busy;
    logic [NC*16-1:0]   toggle_count;

    always #5 clk = ~clk;

    bounce_gen_multi #(
        .NUM_CHANNELS      (NC),
        .BOUNCE_CLOCKS_MIN (BCMIN),
        .BOUNCE_CLOCKS_MAX (BCMAX),
        .NUM_BOUNCES_MIN   (NBMIN),
        .NUM_BOUNCES_MAX   (NBMAX),
        .LFSR_SEED         (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .bounce_out   (bounce_out),
        .busy         (busy),
        .toggle_count (toggle_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: each transition is a list of scheduled toggle edges.
    logic [15:0] m_lfsr   [NC];
    bit          m_active [NC];
    bit          m_target [NC];
    bit          m_out    [NC];
    longint      m_next   [NC];
    int          m_left   [NC];
    int          m_cnt    [NC];
    longint      edge_no;

    function automatic logic [15:0] seed_of(input int c);
        logic [15:0] s;
        s = SEED + 16'(c);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic int rnd(input logic [15:0] l, input int unsigned lo, input int unsigned hi);
        longint lv;
        lv = l;
        return int'(lo) + int'((lv * longint'(hi - lo + 1)) / 65536);
    endfunction

    task automatic model_reset();
        edge_no = 0;
        for (int c = 0; c < NC; c++) begin
            m_lfsr[c]   = seed_of(c);
            m_active[c] = 0;
            m_target[c] = 0;
            m_out[c]    = 0;
            m_left[c]   = 0;
            m_cnt[c]    = 0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] l;
        bit s;
        edge_no++;
        for (int c = 0; c < NC; c++) begin
            l = m_lfsr[c];
            s = sig_in[c];
            if (!m_active[c]) begin
                if (s != m_out[c]) begin
                    m_active[c] = 1;
                    m_target[c] = s;
                    m_left[c]   = 2 * rnd(l, NBMIN, NBMAX) - 1;
                    m_next[c]   = edge_no + rnd(l, BCMIN, BCMAX);
                end
            end else if (s != m_target[c]) begin
                m_active[c] = 0;
            end else if (edge_no == m_next[c]) begin
                m_out[c] = ~m_out[c];
                if (m_cnt[c] < 65535) m_cnt[c]++;
                m_left[c]--;
                if (m_left[c] == 0) m_active[c] = 0;
                else m_next[c] = edge_no + rnd(l, BCMIN, BCMAX);
            end
            m_lfsr[c] = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0]    exp_out;
        logic [NC-1:0]    exp_busy;
        logic [NC*16-1:0] exp_tc;
        exp_tc = '0;
        for (int c = 0; c < NC; c++) begin
            exp_out[c]  = m_out[c];
            exp_busy[c] = m_active[c];
`ifdef BOUNCE_GEN_STATS_EN
            exp_tc[c*16 +: 16] = 16'(m_cnt[c]);
`endif
        end
        check_val("bounce_out", 64'(bounce_out), 64'(exp_out));
        check_val("busy", 64'(busy), 64'(exp_busy));
        check_val("toggle_count", 64'(toggle_count), 64'(exp_tc));
    endtask

    int  ch1_seen = 0;
    bit  prev1 = 0;

    initial begin
        rst    = 1'b1;
        sig_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("reset_bounce_out", 64'(bounce_out), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_toggle_count", 64'(toggle_count), 64'd0);
        rst = 1'b0;

        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == RST_AT) begin
                // Reset asserted mid-activity must clear outputs without a clock edge.
                rst = 1'b1;
                #1;
                check_val("midrst_bounce_out", 64'(bounce_out), 64'd0);
                check_val("midrst_busy", 64'(busy), 64'd0);
                check_val("midrst_toggle_count", 64'(toggle_count), 64'd0);
                model_reset();
                sig_in = '1;
                prev1  = 0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                for (int c = 0; c < NC; c++)
                    if ($urandom_range(0, 99) == 0) sig_in[c] = ~sig_in[c];
            end
            @(posedge clk);
            if (!rst) model_edge();
            @(negedge clk);
            check_outputs();
            if (cyc == RST_AT)
                check_val("restart_busy", 64'(busy), 64'({NC{1'b1}}));
            if (bounce_out[1] != prev1) ch1_seen++;
            prev1 = bounce_out[1];
        end

        check_val("ch1_wrapped_seed_bounces", 64'(ch1_seen != 0), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
